// File: rtl/dpe_pkg.sv
// Shared types and helpers for the dot-product engine: default lane packing,
// a width-generic saturating signed add and a lane offset helper.
package dpe_pkg;

   localparam int unsigned DefLanes = 16;
   localparam int unsigned DefIprec = 8;
   localparam int unsigned DefOprec = 32;

   // Widest accumulator the saturating adder supports.
   localparam int unsigned MaxW = 64;

   typedef struct packed {
      logic                   sat;
      logic signed [MaxW-1:0] val;
   } sat_res_t;

   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned prec);
      return lane * prec;
   endfunction

   // Operands are w-bit values sign-extended to MaxW; the result is clamped to w bits signed.
   function automatic sat_res_t sat_add(input logic signed [MaxW-1:0] a,
                                        input logic signed [MaxW-1:0] b,
                                        input int unsigned            w);
      logic signed [MaxW:0] sum;
      logic signed [MaxW:0] hi;
      logic signed [MaxW:0] lo;
      sat_res_t             r;
      sum = {a[MaxW-1], a} + {b[MaxW-1], b};
      hi  = ((MaxW+1)'(1) << (w - 1)) - (MaxW+1)'(1);
      lo  = ~hi;
      if (sum > hi) begin
         r.sat = 1'b1;
         r.val = hi[MaxW-1:0];
      end else if (sum < lo) begin
         r.sat = 1'b1;
         r.val = lo[MaxW-1:0];
      end else begin
         r.sat = 1'b0;
         r.val = sum[MaxW-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/dpe_adder_tree.sv
// Pipelined binary adder tree; each level adds pairs (i, i+N/2) one bit wider,
// with valid/last sidebands registered alongside the data.
module dpe_adder_tree #(
   parameter int unsigned LANES = 16,
   parameter int unsigned INW   = 16
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  valid_i,
   input  logic                                  last_i,
   input  logic [LANES*INW-1:0]                  data_i,
   output logic                                  valid_o,
   output logic                                  last_o,
   output logic signed [INW+$clog2(LANES)-1:0]   sum_o
);
   localparam int unsigned STAGES = $clog2(LANES);

   for (genvar k = 0; k <= STAGES; k++) begin : g_lvl
      localparam int unsigned W = INW + k;
      localparam int unsigned N = LANES >> k;
      logic signed [W-1:0] lvl_sum [N];
      logic                lvl_vld;
      logic                lvl_lst;

      if (k == 0) begin : g_in
         for (genvar i = 0; i < N; i++) begin : g_lane
            assign lvl_sum[i] = data_i[i*INW +: INW];
         end
         assign lvl_vld = valid_i;
         assign lvl_lst = last_i;
      end else begin : g_add
         logic signed [W-1:0] sum_d [N];
         logic signed [W-1:0] sum_q [N];
         logic                vld_q;
         logic                lst_q;

         always_comb begin
            for (int i = 0; i < N; i++) begin
               sum_d[i] = W'(g_lvl[k-1].lvl_sum[i]) + W'(g_lvl[k-1].lvl_sum[i+N]);
            end
         end

         always_ff @(posedge clk_i) begin
            sum_q <= sum_d;
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               vld_q <= 1'b0;
               lst_q <= 1'b0;
            end else begin
               vld_q <= g_lvl[k-1].lvl_vld;
               lst_q <= g_lvl[k-1].lvl_lst;
            end
         end

         assign lvl_sum = sum_q;
         assign lvl_vld = vld_q;
         assign lvl_lst = lst_q;
      end
   end

   assign sum_o   = g_lvl[STAGES].lvl_sum[0];
   assign valid_o = g_lvl[STAGES].lvl_vld;
   assign last_o  = g_lvl[STAGES].lvl_lst;

endmodule

// File: rtl/dpe_acc.sv
// Dot-product engine: input register, per-lane multiply, adder tree and a
// saturating multi-beat accumulator emitting one result per vector.
module dpe_acc
   import dpe_pkg::*;
#(
   parameter int unsigned LANES        = DefLanes,
   parameter int unsigned IPREC        = DefIprec,
   parameter int unsigned DATAW        = LANES * IPREC,
   parameter int unsigned MPREC        = 2 * IPREC,
   parameter int unsigned ADDER_STAGES = $clog2(LANES),
   parameter int unsigned OPREC        = DefOprec
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_valid,
   input  logic                    i_last,
   input  logic [DATAW-1:0]        i_dataa,
   input  logic [DATAW-1:0]        i_datab,
   output logic                    o_valid,
   output logic signed [OPREC-1:0] o_result,
   output logic                    o_sat
);
   localparam int unsigned TREEW = MPREC + ADDER_STAGES;

   logic [DATAW-1:0]        a_d, a_q, b_d, b_q;
   logic                    vld_i_d, vld_i_q, last_i_d, last_i_q;
   logic signed [MPREC-1:0] prod_d [LANES];
   logic signed [MPREC-1:0] prod_q [LANES];
   logic                    vld_m_d, vld_m_q, last_m_d, last_m_q;
   logic [LANES*MPREC-1:0]  prod_flat;
   logic                    tree_vld, tree_last;
   logic signed [TREEW-1:0] tree_sum;
   logic signed [OPREC-1:0] acc_d, acc_q, base, res_d, res_q;
   logic                    open_d, open_q, sat_acc_d, sat_acc_q, sat_nxt;
   logic                    osat_d, osat_q, ovld_d, ovld_q;
   sat_res_t                sum_r;

   always_comb begin
      a_d      = i_dataa;
      b_d      = i_datab;
      vld_i_d  = i_valid;
      last_i_d = i_valid & i_last;
      vld_m_d  = vld_i_q;
      last_m_d = last_i_q;
      for (int j = 0; j < LANES; j++) begin
         prod_d[j] = MPREC'(signed'(a_q[lane_lsb(j, IPREC) +: IPREC]))
                   * MPREC'(signed'(b_q[lane_lsb(j, IPREC) +: IPREC]));
      end
   end

   always_ff @(posedge clk) begin
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
   end

   for (genvar j = 0; j < LANES; j++) begin : g_flat
      assign prod_flat[j*MPREC +: MPREC] = prod_q[j];
   end

   dpe_adder_tree #(
      .LANES (LANES),
      .INW   (MPREC)
   ) u_tree (
      .clk_i   (clk),
      .rst_ni  (rst),
      .valid_i (vld_m_q),
      .last_i  (last_m_q),
      .data_i  (prod_flat),
      .valid_o (tree_vld),
      .last_o  (tree_last),
      .sum_o   (tree_sum)
   );

   always_comb begin
      acc_d     = acc_q;
      open_d    = open_q;
      sat_acc_d = sat_acc_q;
      res_d     = res_q;
      osat_d    = osat_q;
      ovld_d    = 1'b0;
      base      = open_q ? acc_q : '0;
      sum_r     = sat_add(MaxW'(base), MaxW'(tree_sum), OPREC);
      sat_nxt   = sum_r.sat | (open_q & sat_acc_q);
      if (tree_vld) begin
         if (tree_last) begin
            res_d     = OPREC'(sum_r.val);
            osat_d    = sat_nxt;
            ovld_d    = 1'b1;
            acc_d     = '0;
            open_d    = 1'b0;
            sat_acc_d = 1'b0;
         end else begin
            acc_d     = OPREC'(sum_r.val);
            open_d    = 1'b1;
            sat_acc_d = sat_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_i_q   <= 1'b0;
         last_i_q  <= 1'b0;
         vld_m_q   <= 1'b0;
         last_m_q  <= 1'b0;
         acc_q     <= '0;
         open_q    <= 1'b0;
         sat_acc_q <= 1'b0;
         res_q     <= '0;
         osat_q    <= 1'b0;
         ovld_q    <= 1'b0;
      end else begin
         vld_i_q   <= vld_i_d;
         last_i_q  <= last_i_d;
         vld_m_q   <= vld_m_d;
         last_m_q  <= last_m_d;
         acc_q     <= acc_d;
         open_q    <= open_d;
         sat_acc_q <= sat_acc_d;
         res_q     <= res_d;
         osat_q    <= osat_d;
         ovld_q    <= ovld_d;
      end
   end

   assign o_valid  = ovld_q;
   assign o_result = res_q;
   assign o_sat    = osat_q;

endmodule

// File: tb/tb_dpe_acc.sv
// Bench for dpe_acc: default (32-bit) and 20-bit accumulator instances share
// stimulus; a scoreboard per instance checks result, sat flag and latency.
module tb_dpe_acc;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_valid = 1'b0;
   logic              i_last = 1'b0;
   logic [127:0]      i_dataa = '0;
   logic [127:0]      i_datab = '0;
   logic              o_valid32, o_sat32, o_valid20, o_sat20;
   logic signed [31:0] o_result32;
   logic signed [19:0] o_result20;

   always #5 clk = ~clk;

   dpe_acc u_dut32 (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (i_valid),
      .i_last   (i_last),
      .i_dataa  (i_dataa),
      .i_datab  (i_datab),
      .o_valid  (o_valid32),
      .o_result (o_result32),
      .o_sat    (o_sat32)
   );

   dpe_acc #(
      .OPREC (20)
   ) u_dut20 (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (i_valid),
      .i_last   (i_last),
      .i_dataa  (i_dataa),
      .i_datab  (i_datab),
      .o_valid  (o_valid20),
      .o_result (o_result20),
      .o_sat    (o_sat20)
   );

   typedef struct {
      int     a;
      int     b;
      int     beats;
      bit     bubble;
      longint exp32;
      bit     sat32;
      longint exp20;
      bit     sat20;
   } vec_t;

   typedef struct {
      longint res;
      bit     sat;
      longint cyc;
   } exp_t;

   exp_t   q32[$];
   exp_t   q20[$];
   int     n_cmp = 0;
   int     n_err = 0;
   longint cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic logic [127:0] splat(input int x);
      logic [127:0] v;
      for (int j = 0; j < 16; j++) v[j*8 +: 8] = 8'(x);
      return v;
   endfunction

   function automatic logic [127:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic beat(input logic v, input logic l, input logic [127:0] a,
                       input logic [127:0] b);
      @(posedge clk);
      #1;
      i_valid = v;
      i_last  = l;
      i_dataa = a;
      i_datab = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1'b0, rnd(), rnd());
   endtask

   task automatic push(input longint r32, input bit s32, input longint r20, input bit s20);
      exp_t e;
      e.cyc = cyc;
      e.res = r32;
      e.sat = s32;
      q32.push_back(e);
      e.res = r20;
      e.sat = s20;
      q20.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (o_valid32 === 1'b1) begin
         if (q32.size() == 0) chk("spurious_valid32", 1, 0);
         else begin
            e = q32.pop_front();
            chk("result32", o_result32, e.res);
            chk("sat32", o_sat32, e.sat);
            chk("latency32", cyc - e.cyc, 7);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (o_valid20 === 1'b1) begin
         if (q20.size() == 0) chk("spurious_valid20", 1, 0);
         else begin
            e = q20.pop_front();
            chk("result20", o_result20, e.res);
            chk("sat20", o_sat20, e.sat);
            chk("latency20", cyc - e.cyc, 7);
         end
      end
   end

   initial begin
      vec_t         vecs[9];
      logic [127:0] a1, b1, a2, b2;
      bit           last;

      vecs[0] = '{1, 1, 1, 0, 16, 0, 16, 0};
      vecs[1] = '{-128, -128, 1, 0, 262144, 0, 262144, 0};
      vecs[2] = '{2, 3, 3, 1, 288, 0, 288, 0};
      vecs[3] = '{-128, -128, 2, 0, 524288, 0, 524287, 1};
      vecs[4] = '{1, 1, 1, 0, 16, 0, 16, 0};
      vecs[5] = '{-128, 127, 3, 0, -780288, 0, -524288, 1};
      vecs[6] = '{127, 127, 4, 0, 1032256, 0, 524287, 1};
      vecs[7] = '{1, 1, 2, 0, 32, 0, 32, 0};
      vecs[8] = '{-1, 1, 1, 0, -16, 0, -16, 0};

      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid32", o_valid32, 0);
      chk("rst_result32", o_result32, 0);
      chk("rst_sat32", o_sat32, 0);
      chk("rst_valid20", o_valid20, 0);
      chk("rst_result20", o_result20, 0);
      chk("rst_sat20", o_sat20, 0);
      rst = 1'b1;
      idle(2);

      // Vectors run back to back; a bubble carries a stray i_last that must be ignored.
      foreach (vecs[n]) begin
         for (int k = 0; k < vecs[n].beats; k++) begin
            last = (k == vecs[n].beats - 1);
            if (vecs[n].bubble && last) beat(1'b0, 1'b1, rnd(), rnd());
            beat(1'b1, last, splat(vecs[n].a), splat(vecs[n].b));
            if (last) push(vecs[n].exp32, vecs[n].sat32, vecs[n].exp20, vecs[n].sat20);
         end
      end
      idle(12);
      chk("hold32", o_result32, -16);
      chk("hold20", o_result20, -16);

      // Distinct values per lane: sum (j-8)(j+1) = 272, then sum j*(-j) = -1240.
      for (int j = 0; j < 16; j++) begin
         a1[j*8 +: 8] = 8'(j - 8);
         b1[j*8 +: 8] = 8'(j + 1);
         a2[j*8 +: 8] = 8'(j);
         b2[j*8 +: 8] = 8'(-j);
      end
      beat(1'b1, 1'b0, a1, b1);
      beat(1'b1, 1'b1, a2, b2);
      push(-968, 0, -968, 0);
      idle(12);

      // Reset with an open accumulator and a beat in flight.
      beat(1'b1, 1'b0, splat(1), splat(1));
      idle(9);
      beat(1'b1, 1'b0, splat(1), splat(1));
      @(posedge clk);
      #1;
      rst     = 1'b0;
      i_valid = 1'b0;
      i_last  = 1'b0;
      #1;
      chk("midrst_valid32", o_valid32, 0);
      chk("midrst_result32", o_result32, 0);
      chk("midrst_sat32", o_sat32, 0);
      chk("midrst_result20", o_result20, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      idle(10);
      chk("postrst_result32", o_result32, 0);
      chk("postrst_result20", o_result20, 0);
      beat(1'b1, 1'b1, splat(1), splat(1));
      push(16, 0, 16, 0);
      idle(12);

      for (int t = 0; t < 50 && (q32.size() != 0 || q20.size() != 0); t++) idle(1);
      chk("pending32", q32.size(), 0);
      chk("pending20", q20.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dpe_acc.md
# dpe_acc

Parametrised dot-product engine with a generic pipelined adder tree and a multi-beat accumulator. Vectors longer than `LANES` arrive as consecutive beats. Beats are summed into a saturating signed accumulator, and one result is emitted per vector on the beat flagged `i_last`. It sits in the MLP datapath in place of the fixed-width engine and feeds the activation/requantisation stage.

## Interface
- `LANES`, 16: elements per beat; power of two, 2..64
- `IPREC`, 8: signed element width
- `DATAW`, `LANES*IPREC`: packed input bus width
- `MPREC`, `2*IPREC`: product width
- `ADDER_STAGES`, `$clog2(LANES)`: tree depth
- `OPREC`, 32: accumulator/result width; must be >= `MPREC+ADDER_STAGES`
- `clk`  input  1  clock, rising edge
- `rst`  input  1  reset, asynchronous, active-low
- `i_valid`  input  1  beat valid
- `i_last`  input  1  final beat of current vector; qualified by `i_valid`
- `i_dataa`  input  DATAW  lane j at bits `[(j+1)*IPREC-1 : j*IPREC]`, signed
- `i_datab`  input  DATAW  same packing as `i_dataa`
- `o_valid`  output  1  one-cycle pulse, result valid
- `o_result`  output  OPREC  signed vector dot product, saturated
- `o_sat`  output  1  saturation occurred anywhere in this vector; qualified by `o_valid`

## Operation
- No backpressure; the engine accepts one beat per cycle, every cycle.
- Stage I: register the lanes, `i_valid` and `i_last`.
- Stage M: per lane, signed `a*b` into `MPREC` bits.
- Stages T1..T`ADDER_STAGES`: binary tree.
  - Stage k sums pairs (i, i+N/2) into `MPREC+k` bits, sign-extended.
  - The final sum is `MPREC+ADDER_STAGES` bits wide, so the tree never overflows.
- Stage A (accumulate), acting only on a valid tree output:
  - `sum = (open ? acc : 0) + sext(tree)`, computed at `OPREC+1` bits.
  - `sum` is clamped to [-2^(OPREC-1), 2^(OPREC-1)-1].
  - A sticky `sat_acc` flag is set when clamping occurs and is ORed with the previous flag while `open`.
- Non-last beat:
  - `acc <= clamped`, `open <= 1`.
  - No output pulse.
- Last beat:
  - `o_result <= clamped`, `o_sat <= sat_acc_next`, `o_valid <= 1`.
  - `acc <= 0`, `open <= 0`, `sat_acc <= 0`.
- Accumulation continues from the clamped value; there is no wrap-around.
- Bubbles (`i_valid=0`) propagate as invalid and do not change `acc`, `open` or the outputs.
- `i_last` on the first beat gives a single-beat vector, equal to the plain dot product.
- `i_last` with `i_valid=0` is ignored.
- Back-to-back vectors (last, then next first beat on the following cycle) never share accumulator state.

## Timing
- Latency from the `i_valid`/`i_last` beat to `o_valid` is `ADDER_STAGES+3` cycles. With defaults this is 7.
- Throughput is one beat per cycle. The minimum spacing between `o_valid` pulses is 1 cycle.
- Reset values are all zero: pipeline valids, `acc`, `open`, `sat_acc`, `o_valid`, `o_result`, `o_sat`.
- Reset asserted mid-vector:
  - All in-flight beats are discarded and no `o_valid` is produced for them.
  - The first vector after deassertion starts from `acc=0`.
- `o_result` and `o_sat` hold their value between pulses.
- Data registers may be left unreset. Valid bits and accumulator state must be reset.

## Structure
- Package `dpe_pkg`:
  - signed saturating-add function (`OPREC`-generic via width parameters)
  - lane-extract helper
  - lane-packing constants
- Sub-module `dpe_adder_tree`:
  - parameters `LANES`, `INW`
  - generate-loop stages, with a valid and last sideband shifted alongside the data
  - output width `INW+$clog2(LANES)`
- The top level (`dpe_acc`) holds the input/multiply stages and the accumulator.

## Test plan
- Single-beat vector, all lanes a=1, b=1, `i_last=1`: `o_valid` pulses 7 cycles later, `o_result`=16, `o_sat`=0.
- All lanes a=-128, b=-128, single beat: `o_result`=262144, `o_sat`=0. Checks the signed extreme product.
- Three beats of a=2, b=3 (96 each), with a bubble between beats 2 and 3, last on beat 3: exactly one pulse, `o_result`=288, and no pulse for the earlier beats.
- `OPREC`=20, two beats of a=b=-128 then last: raw sum 524288 is clamped, so `o_result`=524287 and `o_sat`=1. The next vector (a=b=1, single beat) gives 16 with `o_sat`=0.
- Vector A (2 beats, +1 per product) immediately followed by vector B (1 beat, a=-1, b=1): results 32 then -16 on consecutive cycles.
- `rst` low for 1 cycle after beat 1 of a 3-beat vector: no `o_valid` for that vector, all outputs read 0. A fresh single-beat vector of ones then yields 16.
